// File: rtl/hazard_fwd_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_unit_if
// Description : ID-stage hazard information in, EX forwarding selects and
//               load-use stall out.
//   master : drives the ID instruction fields and flush, observes the result
//   slave  : the hazard/forwarding unit
//   id_rs/id_rt/id_use_rs/id_use_rt : ID source registers and their use flags
//   id_dst/id_regwrite/id_memread   : ID destination, write enable, load flag
//   flush                           : kill the ID instruction
//   fwd_a_sel/fwd_b_sel             : EX operand mux selects (00 RF, 01 MEM, 10 WB)
//   stall/stall_cnt                 : load-use stall and saturating stall count
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_fwd_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_dst;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_memread, flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_memread, flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_unit
// Description : Tracks the in-flight instructions in EX, MEM and WB, drives the
//               EX operand forwarding selects, raises the one-cycle load-use
//               stall and counts stall cycles (saturating).
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_fwd_unit_if.slave (ID fields in, selects/stall/count out)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  hazard_fwd_unit_if.slave bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // EX keeps the consumer's source fields; the later slots only ever act as
  // producers, so the load flag is only needed while the instruction is in EX.
  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } ex_slot_t;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [REG_W-1:0] dst;
  } wr_slot_t;

  ex_slot_t         ex_q, ex_d;
  wr_slot_t         mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic       mem_wr_ok, wb_wr_ok;
  logic [1:0] sel_a, sel_b;
  logic       load_use, stall;

  // A slot can only forward when it really writes a non-zero register.
  assign mem_wr_ok = mem_q.valid & mem_q.regwrite & (mem_q.dst != '0);
  assign wb_wr_ok  = wb_q.valid  & wb_q.regwrite  & (wb_q.dst  != '0);

  // MEM is checked first: it holds the younger producer.
  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    if (ex_q.use_rs) begin
      if (mem_wr_ok && (mem_q.dst == ex_q.rs))     sel_a = SEL_MEM;
      else if (wb_wr_ok && (wb_q.dst == ex_q.rs))  sel_a = SEL_WB;
    end
    if (ex_q.use_rt) begin
      if (mem_wr_ok && (mem_q.dst == ex_q.rt))     sel_b = SEL_MEM;
      else if (wb_wr_ok && (wb_q.dst == ex_q.rt))  sel_b = SEL_WB;
    end
  end

  assign load_use = ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.dst != '0) &
                    ((bus.id_use_rs & (bus.id_rs == ex_q.dst)) |
                     (bus.id_use_rt & (bus.id_rt == ex_q.dst)));

  // A flushed ID instruction never reaches EX, so it cannot need a stall.
  assign stall = load_use & ~bus.flush;

  always_comb begin
    ex_d = '0;
    if (!(stall || bus.flush)) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = bus.id_regwrite;
      ex_d.memread  = bus.id_memread;
      ex_d.dst      = bus.id_dst;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.use_rs   = bus.id_use_rs;
      ex_d.use_rt   = bus.id_use_rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_q           <= mem_q;
      mem_q.valid    <= ex_q.valid;
      mem_q.regwrite <= ex_q.regwrite;
      mem_q.dst      <= ex_q.dst;
      ex_q           <= ex_d;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.fwd_a_sel = sel_a;
  assign bus.fwd_b_sel = sel_b;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
